// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
//
// Writable instruction-pointer memory for the fetch stage, plus a small table
// of program entry points. After Reset the block sits in LOAD, where a loader
// fills memory words and entry slots. ld_done moves it to RUN, where the fetch
// stage reads words by PC with one cycle of latency. Only Reset returns the
// block to LOAD. Memory contents survive Reset; everything else is cleared.
//
// Optional build macro: IMEM_PARITY_EN
//   When defined, every stored word carries an even-parity bit written with
//   the word. A fetch whose stored parity disagrees with the stored data sets
//   err; iptr still returns the stored data.
//
// Ports:
//   Clk        in   1          system clock, rising edge
//   Reset      in   1          synchronous, active-high reset
//   ld_en      in   1          write ld_data into mem[ld_addr] (LOAD only)
//   ld_addr    in   PC_W       loader word address / entry-point value
//   ld_data    in   IW         loader word data
//   ep_we      in   1          write ld_addr into entry slot ep_idx (LOAD only)
//   ep_idx     in   PSEL_W     entry-point slot index
//   ld_done    in   1          end of load, go to RUN
//   prog_sel   in   PSEL_W     selects the entry slot shown on start_pc
//   fetch_req  in   1          fetch mem[PC] (RUN only)
//   PC         in   PC_W       fetch address
//   iptr       out  IW         fetched word, registered
//   iptr_valid out  1          iptr was updated by the previous cycle's fetch
//   start_pc   out  PC_W       registered entry[prog_sel]
//   ready      out  1          block is in RUN
//   ld_count   out  PC_W+1     accepted loader writes, saturating at DEPTH
//   err        out  1          sticky protocol / range / parity error
// -----------------------------------------------------------------------------
module imem_loadable #(
  parameter int PC_W   = 8,
  parameter int IW     = 9,
  parameter int DEPTH  = 256,
  parameter int NPROG  = 4,
  parameter int PSEL_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld_en,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [IW-1:0]     ld_data,
  input  logic              ep_we,
  input  logic [PSEL_W-1:0] ep_idx,
  input  logic              ld_done,
  input  logic [PSEL_W-1:0] prog_sel,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   PC,
  output logic [IW-1:0]     iptr,
  output logic              iptr_valid,
  output logic [PC_W-1:0]   start_pc,
  output logic              ready,
  output logic [PC_W:0]     ld_count,
  output logic              err
);

  // Array index width; DEPTH <= 2**PC_W guarantees AW <= PC_W.
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0] DEPTH_V = (PC_W + 1)'(DEPTH);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [IW-1:0]     iptr_q, iptr_d;
  logic              iptr_valid_q, iptr_valid_d;
  logic [PC_W-1:0]   start_pc_q, start_pc_d;
  logic [PC_W:0]     ld_count_q, ld_count_d;
  logic              err_q, err_d;
  logic [PC_W-1:0]   entry_q [NPROG];
  logic [PC_W-1:0]   entry_d [NPROG];

  logic [IW-1:0]     mem [DEPTH];

  logic              mem_we;
  logic              ld_in_range;
  logic              pc_in_range;
  logic [IW-1:0]     rd_word;
  logic              par_err;

  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_V);
  assign pc_in_range = ({1'b0, PC} < DEPTH_V);
  assign rd_word     = mem[PC[AW-1:0]];

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      par_mem[ld_addr[AW-1:0]] <= ^ld_data;
    end
  end

  // Even parity: stored bit equals the XOR of the stored data bits.
  assign par_err = pc_in_range && (par_mem[PC[AW-1:0]] != ^rd_word);
`else
  assign par_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d      = state_q;
    iptr_d       = iptr_q;
    iptr_valid_d = 1'b0;
    ld_count_d   = ld_count_q;
    err_d        = err_q;
    entry_d      = entry_q;
    mem_we       = 1'b0;
    start_pc_d   = entry_q[prog_sel];

    unique case (state_q)
      ST_LOAD: begin
        if (ld_en) begin
          if (ld_in_range) begin
            // Gated by Reset so a write in the reset cycle is dropped.
            mem_we = !Reset;
            if (ld_count_q != DEPTH_V) begin
              ld_count_d = ld_count_q + (PC_W + 1)'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
        if (ep_we) begin
          entry_d[ep_idx] = ld_addr;
        end
        if (ld_done) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (fetch_req) begin
          iptr_valid_d = 1'b1;
          if (pc_in_range) begin
            iptr_d = rd_word;
            if (par_err) begin
              err_d = 1'b1;
            end
          end else begin
            // Out-of-range fetch returns the halt word.
            iptr_d = '0;
            err_d  = 1'b1;
          end
        end
        // The loader is locked out once running.
        if (ld_en || ep_we) begin
          err_d = 1'b1;
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order within the block.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_LOAD;
      iptr_q       <= '0;
      iptr_valid_q <= 1'b0;
      start_pc_q   <= '0;
      ld_count_q   <= '0;
      err_q        <= 1'b0;
      entry_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      iptr_q       <= iptr_d;
      iptr_valid_q <= iptr_valid_d;
      start_pc_q   <= start_pc_d;
      ld_count_q   <= ld_count_d;
      err_q        <= err_d;
      entry_q      <= entry_d;
    end
  end

  // NOTE: the word array has no reset; its contents must survive Reset, and a
  // reset port would also stop it mapping onto a RAM macro.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  assign iptr       = iptr_q;
  assign iptr_valid = iptr_valid_q;
  assign start_pc   = start_pc_q;
  assign ready      = (state_q == ST_RUN);
  assign ld_count   = ld_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loadable.sv
// -----------------------------------------------------------------------------
// tb_imem_loadable
//
// Directed bench for imem_loadable. Two instances share every input: u_dut
// with the default DEPTH=256 and u_dut64 with DEPTH=64, so the same stimulus
// exercises in-range behaviour on one and range errors on the other.
// Inputs change 1 ns after a rising edge; outputs are sampled at that moment.
// -----------------------------------------------------------------------------
module tb_imem_loadable;

  localparam int PC_W   = 8;
  localparam int IW     = 9;
  localparam int PSEL_W = 2;

  logic              Clk;
  logic              Reset;
  logic              ld_en;
  logic [PC_W-1:0]   ld_addr;
  logic [IW-1:0]     ld_data;
  logic              ep_we;
  logic [PSEL_W-1:0] ep_idx;
  logic              ld_done;
  logic [PSEL_W-1:0] prog_sel;
  logic              fetch_req;
  logic [PC_W-1:0]   PC;

  logic [IW-1:0]     iptr,       iptr_s;
  logic              iptr_valid, iptr_valid_s;
  logic [PC_W-1:0]   start_pc,   start_pc_s;
  logic              ready,      ready_s;
  logic [PC_W:0]     ld_count,   ld_count_s;
  logic              err,        err_s;

  int checks   = 0;
  int failures = 0;

  imem_loadable u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ep_we     (ep_we),
    .ep_idx    (ep_idx),
    .ld_done   (ld_done),
    .prog_sel  (prog_sel),
    .fetch_req (fetch_req),
    .PC        (PC),
    .iptr      (iptr),
    .iptr_valid(iptr_valid),
    .start_pc  (start_pc),
    .ready     (ready),
    .ld_count  (ld_count),
    .err       (err)
  );

  imem_loadable #(.DEPTH(64)) u_dut64 (
    .Clk       (Clk),
    .Reset     (Reset),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ep_we     (ep_we),
    .ep_idx    (ep_idx),
    .ld_done   (ld_done),
    .prog_sel  (prog_sel),
    .fetch_req (fetch_req),
    .PC        (PC),
    .iptr      (iptr_s),
    .iptr_valid(iptr_valid_s),
    .start_pc  (start_pc_s),
    .ready     (ready_s),
    .ld_count  (ld_count_s),
    .err       (err_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset     = 1'b1;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    ep_we     = 1'b0;
    ep_idx    = '0;
    ld_done   = 1'b0;
    prog_sel  = 2'd2;
    fetch_req = 1'b0;
    PC        = '0;

    // ---- reset state
    tick();
    tick();
    check("rst_iptr",       32'(iptr),       32'h0);
    check("rst_iptr_valid", 32'(iptr_valid), 32'h0);
    check("rst_start_pc",   32'(start_pc),   32'h0);
    check("rst_ready",      32'(ready),      32'h0);
    check("rst_ld_count",   32'(ld_count),   32'h0);
    check("rst_err",        32'(err),        32'h0);
    check("rst_err_64",     32'(err_s),      32'h0);
    Reset = 1'b0;

    // ---- load words
    ld_en = 1'b1; ld_addr = 8'd0;  ld_data = 9'h001; tick();
    ld_addr = 8'd27; ld_data = 9'h000; tick();
    ld_addr = 8'd10; ld_data = 9'h0A5; tick();
    ld_addr = 8'd5;  ld_data = 9'h055; tick();
    // word write and entry write in the same cycle
    ld_addr = 8'd3;  ld_data = 9'h003; ep_we = 1'b1; ep_idx = 2'd1; tick();
    check("ld_count_5", 32'(ld_count), 32'd5);

    // ---- entry table: slot 2 = 48, no word write
    ld_en = 1'b0; ep_we = 1'b1; ep_idx = 2'd2; ld_addr = 8'd48; tick();
    check("start_pc_n1",        32'(start_pc), 32'd0);
    check("ld_count_ep_only",   32'(ld_count), 32'd5);
    ep_we = 1'b0; tick();
    check("start_pc_n2",        32'(start_pc),   32'd48);
    check("start_pc_n2_64",     32'(start_pc_s), 32'd48);
    prog_sel = 2'd1; tick();
    check("start_pc_slot1",     32'(start_pc), 32'd3);

    // ---- write in the ld_done cycle still completes
    ld_en = 1'b1; ld_addr = 8'd60; ld_data = 9'h13C; ld_done = 1'b1; tick();
    ld_en = 1'b0; ld_done = 1'b0;
    check("ready_run",      32'(ready),      32'h1);
    check("ready_run_64",   32'(ready_s),    32'h1);
    check("ld_count_6",     32'(ld_count),   32'd6);
    check("err_after_load", 32'(err),        32'h0);

    // ---- back-to-back fetches
    fetch_req = 1'b1; PC = 8'd0; tick();
    check("f0_iptr",  32'(iptr),       32'h001);
    check("f0_valid", 32'(iptr_valid), 32'h1);
    PC = 8'd27; tick();
    check("f27_iptr",  32'(iptr),       32'h000);
    check("f27_valid", 32'(iptr_valid), 32'h1);
    PC = 8'd60; tick();
    check("f60_iptr",  32'(iptr),       32'h13C);
    check("f60_valid", 32'(iptr_valid), 32'h1);
    fetch_req = 1'b0; tick();
    check("idle_valid", 32'(iptr_valid), 32'h0);
    check("idle_hold",  32'(iptr),       32'h13C);

    // ---- loader write while running is refused
    ld_en = 1'b1; ld_addr = 8'd5; ld_data = 9'h1FF; tick();
    ld_en = 1'b0;
    check("run_ld_err",      32'(err),      32'h1);
    check("run_ld_err_64",   32'(err_s),    32'h1);
    check("run_ld_count",    32'(ld_count), 32'd6);
    fetch_req = 1'b1; PC = 8'd5; tick();
    check("f5_old_word", 32'(iptr), 32'h055);

    // ---- Reset mid-fetch, then a write dropped by Reset mid-load
    PC = 8'd10; Reset = 1'b1; tick();
    check("midrst_valid",    32'(iptr_valid), 32'h0);
    check("midrst_iptr",     32'(iptr),       32'h0);
    check("midrst_err",      32'(err),        32'h0);
    check("midrst_ready",    32'(ready),      32'h0);
    check("midrst_start_pc", 32'(start_pc),   32'h0);
    fetch_req = 1'b0;
    ld_en = 1'b1; ld_addr = 8'd10; ld_data = 9'h1FF; tick();
    check("midrst_ld_count", 32'(ld_count), 32'd0);
    Reset = 1'b0;

    // ---- loader range on the DEPTH=64 instance
    ld_addr = 8'd70; ld_data = 9'h046; tick();
    check("ld70_err_64",   32'(err_s),      32'h1);
    check("ld70_count_64", 32'(ld_count_s), 32'd0);
    check("ld70_err",      32'(err),        32'h0);
    check("ld70_count",    32'(ld_count),   32'd1);
    ld_addr = 8'd100; ld_data = 9'h0C3; tick();
    check("ld100_count",    32'(ld_count),   32'd2);
    check("ld100_count_64", 32'(ld_count_s), 32'd0);
    ld_en = 1'b0; ld_done = 1'b1; tick();
    ld_done = 1'b0;

    // ---- retention across Reset
    fetch_req = 1'b1; PC = 8'd10; tick();
    check("keep10_iptr",    32'(iptr),   32'h0A5);
    check("keep10_iptr_64", 32'(iptr_s), 32'h0A5);

    // ---- fetch range on the DEPTH=64 instance
    PC = 8'd100; tick();
    check("f100_iptr_64",  32'(iptr_s),       32'h0);
    check("f100_valid_64", 32'(iptr_valid_s), 32'h1);
    check("f100_err_64",   32'(err_s),        32'h1);
    check("f100_iptr",     32'(iptr),         32'h0C3);
    check("f100_err",      32'(err),          32'h0);

    // ---- parity check on mem[3]
    fetch_req = 1'b0;
`ifdef IMEM_PARITY_EN
    u_dut.par_mem[3] = ~u_dut.par_mem[3];
`endif
    tick();
    fetch_req = 1'b1; PC = 8'd3; tick();
    fetch_req = 1'b0;
    check("f3_iptr", 32'(iptr), 32'h003);
`ifdef IMEM_PARITY_EN
    check("f3_par_err", 32'(err), 32'h1);
`else
    check("f3_err",     32'(err), 32'h0);
`endif

    // ---- ld_count saturation at DEPTH
    Reset = 1'b1; tick();
    Reset = 1'b0;
    for (int i = 0; i < 66; i++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(i % 64);
      ld_data = 9'(i);
      tick();
    end
    ld_en = 1'b0;
    check("sat_count_64", 32'(ld_count_s), 32'd64);
    check("sat_count",    32'(ld_count),   32'd66);
    check("sat_err_64",   32'(err_s),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
